// File: rtl/head_ptr_table.sv
// -----------------------------------------------------------------------------
// head_ptr_table
//
// Bucket head-pointer lookup stage. Each bucket stores {ptr, val} in a simple
// dual-port RAM (one read, one write) with a 2-cycle registered read path.
// Lookup tasks are accepted with a valid/ready handshake. Each accepted task
// reads its bucket entry, and the task plus its {ptr, val} is pushed into a
// 4-entry output FIFO whose head drives the outputs.
//
// After reset the block sweeps the whole table and writes val=0 into every
// entry (CLEAR state) before it accepts lookups (RUN state).
//
// An occupancy counter covers reads in flight plus FIFO entries. It gates
// acceptance, so the FIFO can never overflow and results keep their
// acceptance order.
//
// Optional feature (compile-time macro):
//   HEAD_PTR_TABLE_BYPASS_EN - a head-table write to the bucket of a read that
//   is issued in the same cycle, or is in either read latency stage, replaces
//   that read's result with the written value. The newest write wins.
//   Without the macro, reads return the RAM contents as they were when the
//   read was issued.
//
// Ports:
//   clk_i             - clock, rising edge
//   rst_i             - asynchronous reset, active low
//   task_i            - lookup task payload (opaque, passed through)
//   task_bucket_i     - bucket index to look up
//   task_valid_i      - lookup request valid
//   task_ready_o      - lookup request ready
//   wr_addr_i         - head-table write bucket
//   wr_data_ptr_i     - head-table write pointer
//   wr_data_ptr_val_i - head-table write valid flag
//   wr_en_i           - head-table write enable (ignored while clearing)
//   pdata_o           - task forwarded to the data table
//   head_ptr_o        - head pointer of the looked-up bucket
//   head_ptr_val_o    - valid flag of the looked-up bucket
//   pdata_valid_o     - output valid (FIFO not empty)
//   pdata_ready_i     - output ready
//   clear_busy_o      - high while the clear sweep runs
// -----------------------------------------------------------------------------
module head_ptr_table #(
  parameter int BUCKET_WIDTH = 8,
  parameter int PTR_WIDTH    = 10,
  parameter int TASK_WIDTH   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [TASK_WIDTH-1:0]   task_i,
  input  logic [BUCKET_WIDTH-1:0] task_bucket_i,
  input  logic                    task_valid_i,
  output logic                    task_ready_o,
  input  logic [BUCKET_WIDTH-1:0] wr_addr_i,
  input  logic [PTR_WIDTH-1:0]    wr_data_ptr_i,
  input  logic                    wr_data_ptr_val_i,
  input  logic                    wr_en_i,
  output logic [TASK_WIDTH-1:0]   pdata_o,
  output logic [PTR_WIDTH-1:0]    head_ptr_o,
  output logic                    head_ptr_val_o,
  output logic                    pdata_valid_o,
  input  logic                    pdata_ready_i,
  output logic                    clear_busy_o
);

  localparam int DEPTH  = 1 << BUCKET_WIDTH;
  localparam int ENT_W  = PTR_WIDTH + 1;
  localparam int FIFO_W = TASK_WIDTH + ENT_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [BUCKET_WIDTH-1:0] sweep_r, sweep_nxt_s;

  logic [ENT_W-1:0]        mem_r [DEPTH];
  logic                    ram_we_s;
  logic [BUCKET_WIDTH-1:0] ram_waddr_s;
  logic [ENT_W-1:0]        ram_wdata_s;
  logic [ENT_W-1:0]        wr_ent_s;
  logic [ENT_W-1:0]        ram_rd_s;

  logic                    s1_vld_r, s2_vld_r;
  logic [TASK_WIDTH-1:0]   s1_task_r, s2_task_r;
  logic [ENT_W-1:0]        s1_ent_r, s2_ent_r;
  logic [ENT_W-1:0]        s1_in_s, s2_in_s, fifo_ent_s;

  logic [FIFO_W-1:0]       fifo_mem_r [4];
  logic [1:0]              wr_ptr_r, rd_ptr_r;
  logic [2:0]              fifo_cnt_r, fifo_cnt_nxt_s;
  logic [2:0]              occ_r, occ_nxt_s;

  logic                    task_ready_r, pdata_valid_r, clear_busy_r;
  logic                    accept_s, push_s, pop_s;

  assign wr_ent_s = {wr_data_ptr_i, wr_data_ptr_val_i};
  assign accept_s = task_valid_i && task_ready_r;
  assign push_s   = s2_vld_r;
  assign pop_s    = pdata_valid_r && pdata_ready_i;

  // FSM next state and sweep counter: CLEAR walks every bucket once, then RUN
  always_comb begin
    state_nxt_s = state_r;
    sweep_nxt_s = sweep_r;
    case (state_r)
      ST_CLEAR: begin
        sweep_nxt_s = sweep_r + BUCKET_WIDTH'(1);
        if (sweep_r == {BUCKET_WIDTH{1'b1}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        sweep_nxt_s = sweep_r;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        sweep_nxt_s = '0;
      end
    endcase
  end

  // FSM state and sweep counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_CLEAR;
      sweep_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      sweep_r <= sweep_nxt_s;
    end
  end

  // RAM write port: the clear sweep owns it in CLEAR, the engines own it in RUN
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    if (state_r == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = sweep_r;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = wr_en_i;
      ram_waddr_s = wr_addr_i;
      ram_wdata_s = wr_ent_s;
    end
  end

  // Head table storage; no reset because the clear sweep initialises it
  always_ff @(posedge clk_i) begin
    if (ram_we_s) begin
      mem_r[ram_waddr_s] <= ram_wdata_s;
    end
  end

  assign ram_rd_s = mem_r[task_bucket_i];

`ifdef HEAD_PTR_TABLE_BYPASS_EN
  logic                    user_we_s;
  logic [BUCKET_WIDTH-1:0] s1_addr_r, s2_addr_r;

  assign user_we_s = (state_r == ST_RUN) && wr_en_i;

  // Forwarding: each stage picks up a same-cycle write to its bucket. A stage
  // overwritten later simply takes the later data, so the newest write wins.
  always_comb begin
    s1_in_s    = ram_rd_s;
    s2_in_s    = s1_ent_r;
    fifo_ent_s = s2_ent_r;
    if (user_we_s && (wr_addr_i == task_bucket_i)) begin
      s1_in_s = wr_ent_s;
    end else begin
      s1_in_s = ram_rd_s;
    end
    if (user_we_s && (wr_addr_i == s1_addr_r)) begin
      s2_in_s = wr_ent_s;
    end else begin
      s2_in_s = s1_ent_r;
    end
    if (user_we_s && (wr_addr_i == s2_addr_r)) begin
      fifo_ent_s = wr_ent_s;
    end else begin
      fifo_ent_s = s2_ent_r;
    end
  end

  // Bucket address pipeline, only needed for forwarding comparisons
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_addr_r <= '0;
      s2_addr_r <= '0;
    end else begin
      if (accept_s) begin
        s1_addr_r <= task_bucket_i;
      end
      if (s1_vld_r) begin
        s2_addr_r <= s1_addr_r;
      end
    end
  end
`else
  // No forwarding: the entry read when the lookup was issued is returned
  always_comb begin
    s1_in_s    = ram_rd_s;
    s2_in_s    = s1_ent_r;
    fifo_ent_s = s2_ent_r;
  end
`endif

  // Two-stage read pipeline carrying the task alongside its table entry
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_vld_r  <= 1'b0;
      s2_vld_r  <= 1'b0;
      s1_task_r <= '0;
      s2_task_r <= '0;
      s1_ent_r  <= '0;
      s2_ent_r  <= '0;
    end else begin
      s1_vld_r <= accept_s;
      s2_vld_r <= s1_vld_r;
      if (accept_s) begin
        s1_task_r <= task_i;
        s1_ent_r  <= s1_in_s;
      end
      if (s1_vld_r) begin
        s2_task_r <= s1_task_r;
        s2_ent_r  <= s2_in_s;
      end
    end
  end

  // Occupancy and FIFO fill next values; simultaneous inc/dec cancel out
  always_comb begin
    occ_nxt_s      = occ_r;
    fifo_cnt_nxt_s = fifo_cnt_r;
    case ({accept_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + 3'd1;
      2'b01:   occ_nxt_s = occ_r - 3'd1;
      default: occ_nxt_s = occ_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 3'd1;
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 3'd1;
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Output FIFO storage and pointers; occupancy gating guarantees no overflow
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
      occ_r      <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {s2_task_r, fifo_ent_s};
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
      occ_r      <= occ_nxt_s;
    end
  end

  // Registered handshake/status outputs, computed from next-state values
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      task_ready_r  <= 1'b0;
      pdata_valid_r <= 1'b0;
      clear_busy_r  <= 1'b1;
    end else begin
      task_ready_r  <= (state_nxt_s == ST_RUN) && (occ_nxt_s < 3'd4);
      pdata_valid_r <= (fifo_cnt_nxt_s != 3'd0);
      clear_busy_r  <= (state_nxt_s == ST_CLEAR);
    end
  end

  assign task_ready_o  = task_ready_r;
  assign pdata_valid_o = pdata_valid_r;
  assign clear_busy_o  = clear_busy_r;
  assign {pdata_o, head_ptr_o, head_ptr_val_o} = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_head_ptr_table.sv
// -----------------------------------------------------------------------------
// tb_head_ptr_table
//
// Self-checking bench for head_ptr_table with default parameters. It contains
// a table of write-then-lookup vectors and hand-written sequences for the
// clear sweep, back-pressure, back-to-back throughput, write/read collisions
// (expectations follow HEAD_PTR_TABLE_BYPASS_EN) and reset mid-operation.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_head_ptr_table;

  localparam int BW = 8;
  localparam int PW = 10;
  localparam int TW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [TW-1:0] task_i = '0;
  logic [BW-1:0] task_bucket_i = '0;
  logic          task_valid_i = 1'b0;
  logic          task_ready_o;
  logic [BW-1:0] wr_addr_i = '0;
  logic [PW-1:0] wr_data_ptr_i = '0;
  logic          wr_data_ptr_val_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [TW-1:0] pdata_o;
  logic [PW-1:0] head_ptr_o;
  logic          head_ptr_val_o;
  logic          pdata_valid_o;
  logic          pdata_ready_i = 1'b1;
  logic          clear_busy_o;

  always #5 clk_i = ~clk_i;

  head_ptr_table #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .TASK_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .task_i(task_i), .task_bucket_i(task_bucket_i),
    .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_ptr_i(wr_data_ptr_i),
    .wr_data_ptr_val_i(wr_data_ptr_val_i), .wr_en_i(wr_en_i),
    .pdata_o(pdata_o), .head_ptr_o(head_ptr_o), .head_ptr_val_o(head_ptr_val_o),
    .pdata_valid_o(pdata_valid_o), .pdata_ready_i(pdata_ready_i),
    .clear_busy_o(clear_busy_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW-1:0] wa;
    logic [PW-1:0] wp;
    logic          wv;
    logic [BW-1:0] lb;
    logic [TW-1:0] tk;
    logic [PW-1:0] ep;
    logic          ev;
    bit            chk_ptr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic write_entry(input logic [BW-1:0] a, input logic [PW-1:0] p, input logic v);
    wr_addr_i = a;
    wr_data_ptr_i = p;
    wr_data_ptr_val_i = v;
    wr_en_i = 1'b1;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!task_ready_o && n < 600) begin
      step();
      n++;
    end
    check("ready_wait", {63'd0, task_ready_o}, 64'd1);
  endtask

  // Issue one lookup and wait (bounded) for its result; lat counts cycles
  // from the accepting edge's cycle to the first cycle with pdata_valid_o.
  task automatic lookup(input logic [BW-1:0] b, input logic [TW-1:0] tk, output logic got,
                        output logic [PW-1:0] ptr, output logic v, output logic [TW-1:0] data,
                        output int lat);
    wait_ready();
    task_i = tk;
    task_bucket_i = b;
    task_valid_i = 1'b1;
    step();
    task_valid_i = 1'b0;
    lat = 1;
    while (!pdata_valid_o && lat < 20) begin
      step();
      lat++;
    end
    got = pdata_valid_o;
    ptr = head_ptr_o;
    v = head_ptr_val_o;
    data = pdata_o;
  endtask

  // Release reset and count cycles with clear_busy_o high; also count any
  // cycle in which a lookup could be accepted or a result appears meanwhile.
  task automatic release_and_clear(output int busy, output int stale);
    busy = 0;
    stale = 0;
    rst_i = 1'b1;
    while (clear_busy_o && busy < 1000) begin
      busy++;
      if (pdata_valid_o || task_ready_o) stale++;
      step();
    end
  endtask

  // Lookup with a write to the same bucket issued d cycles after the read
  task automatic collide(input logic [BW-1:0] b, input int d, input logic [PW-1:0] p,
                         input logic [TW-1:0] tk, output logic got, output logic [PW-1:0] ptr,
                         output logic v, output logic [TW-1:0] data);
    int n;
    wait_ready();
    task_i = tk;
    task_bucket_i = b;
    task_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_en_i = (k == d);
      wr_addr_i = b;
      wr_data_ptr_i = p;
      wr_data_ptr_val_i = 1'b1;
      step();
      task_valid_i = 1'b0;
    end
    wr_en_i = 1'b0;
    n = 0;
    while (!pdata_valid_o && n < 20) begin
      step();
      n++;
    end
    got = pdata_valid_o;
    ptr = head_ptr_o;
    v = head_ptr_val_o;
    data = pdata_o;
  endtask

  initial begin
    logic          got, v;
    logic [PW-1:0] ptr;
    logic [TW-1:0] data;
    logic [TW-1:0] expq[4];
    logic [TW-1:0] q[$];
    logic [TW-1:0] hold_d;
    int            lat, busy, stale, nacc, ndr, unstable;

    vecs[0] = '{8'h05, 10'h123, 1'b1, 8'h05, 64'hDEAD_BEEF_0000_0005, 10'h123, 1'b1, 1'b1};
    vecs[1] = '{8'h06, 10'h000, 1'b1, 8'h06, 64'h1111_2222_3333_4444, 10'h000, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 10'h3FF, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 10'h2AA, 1'b1, 8'h00, 64'h0000_0000_0000_0001, 10'h2AA, 1'b1, 1'b1};
    vecs[4] = '{8'h05, 10'h155, 1'b0, 8'h05, 64'hA5A5_5A5A_A5A5_5A5A, 10'h155, 1'b0, 1'b1};
    vecs[5] = '{8'h20, 10'h001, 1'b1, 8'h7F, 64'h0000_7F7F_0000_7F7F, 10'h000, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 10'h0F0, 1'b1, 8'h20, 64'h2020_2020_2020_2020, 10'h001, 1'b1, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_ready", {63'd0, task_ready_o}, 64'd0);
    check("rst_valid", {63'd0, pdata_valid_o}, 64'd0);
    check("rst_busy", {63'd0, clear_busy_o}, 64'd1);
    check("rst_pdata", pdata_o, 64'd0);
    check("rst_ptr", {53'd0, head_ptr_o, head_ptr_val_o}, 64'd0);

    // Clear sweep after release
    release_and_clear(busy, stale);
    check("clear_cycles", busy, 64'd256);
    check("clear_stale", stale, 64'd0);
    check("ready_after_clear", {63'd0, task_ready_o}, 64'd1);

    // Table-driven write-then-lookup vectors
    for (int i = 0; i < 7; i++) begin
      write_entry(vecs[i].wa, vecs[i].wp, vecs[i].wv);
      repeat (4) step();
      lookup(vecs[i].lb, vecs[i].tk, got, ptr, v, data, lat);
      check($sformatf("vec%0d_valid", i), {63'd0, got}, 64'd1);
      if (vecs[i].chk_ptr) check($sformatf("vec%0d_ptr", i), ptr, vecs[i].ep);
      check($sformatf("vec%0d_val", i), {63'd0, v}, {63'd0, vecs[i].ev});
      check($sformatf("vec%0d_task", i), data, vecs[i].tk);
      if (i == 0) check("latency", lat, 64'd3);
      step();
    end

    // Back-pressure: exactly 4 accepts, outputs held, in-order drain
    pdata_ready_i = 1'b0;
    task_bucket_i = 8'h00;
    task_valid_i = 1'b1;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      task_i = 64'hB000_0000_0000_0000 + 64'(c);
      if (task_ready_o) begin
        if (nacc < 4) expq[nacc] = task_i;
        nacc++;
      end
      step();
    end
    task_valid_i = 1'b0;
    check("bp_accepts", nacc, 64'd4);
    check("bp_ready_low", {63'd0, task_ready_o}, 64'd0);
    hold_d = pdata_o;
    unstable = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (pdata_o !== hold_d || !pdata_valid_o || head_ptr_o !== 10'h2AA) unstable++;
    end
    check("bp_hold_stable", unstable, 64'd0);
    pdata_ready_i = 1'b1;
    ndr = 0;
    for (int c = 0; c < 12; c++) begin
      if (pdata_valid_o) begin
        if (ndr < 4) check($sformatf("bp_order%0d", ndr), pdata_o, expq[ndr]);
        ndr++;
      end
      step();
    end
    check("bp_drained", ndr, 64'd4);
    check("bp_ready_back", {63'd0, task_ready_o}, 64'd1);

    // Back-to-back throughput with the sink always ready
    nacc = 0;
    ndr = 0;
    for (int c = 0; c < 16; c++) begin
      if (pdata_valid_o) begin
        if (q.size() > 0) check($sformatf("tp_order%0d", ndr), pdata_o, q.pop_front());
        ndr++;
      end
      task_valid_i = (c < 6);
      task_bucket_i = 8'h06;
      task_i = 64'hC000_0000_0000_0000 + 64'(c);
      if (task_valid_i && task_ready_o) begin
        q.push_back(task_i);
        nacc++;
      end
      step();
    end
    task_valid_i = 1'b0;
    check("tp_accepts", nacc, 64'd6);
    check("tp_drained", ndr, 64'd6);

    // Write colliding with a lookup: same cycle, stage 1, stage 2
    for (int d = 0; d < 3; d++) begin
      collide(8'h10 + 8'(d), d, 10'h3FF - 10'(d), 64'hD000_0000_0000_0000 + 64'(d), got, ptr, v, data);
      check($sformatf("col%0d_valid", d), {63'd0, got}, 64'd1);
      check($sformatf("col%0d_task", d), data, 64'hD000_0000_0000_0000 + 64'(d));
`ifdef HEAD_PTR_TABLE_BYPASS_EN
      check($sformatf("col%0d_ptr", d), ptr, 10'h3FF - 10'(d));
      check($sformatf("col%0d_val", d), {63'd0, v}, 64'd1);
`else
      check($sformatf("col%0d_val", d), {63'd0, v}, 64'd0);
`endif
      step();
    end
    repeat (2) step();
    lookup(8'h10, 64'hE000_0000_0000_0010, got, ptr, v, data, lat);
    check("post_col_ptr", {53'd0, ptr, v}, {53'd0, 10'h3FF, 1'b1});
    step();

    // Reset mid-operation: 3 results pending, 1 read in flight
    pdata_ready_i = 1'b0;
    wait_ready();
    task_valid_i = 1'b1;
    task_bucket_i = 8'h05;
    for (int c = 0; c < 4; c++) begin
      task_i = 64'hF000_0000_0000_0000 + 64'(c);
      step();
    end
    task_valid_i = 1'b0;
    step();
    check("pre_rst_valid", {63'd0, pdata_valid_o}, 64'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, pdata_valid_o}, 64'd0);
    check("mid_rst_ready", {63'd0, task_ready_o}, 64'd0);
    check("mid_rst_busy", {63'd0, clear_busy_o}, 64'd1);
    check("mid_rst_pdata", pdata_o, 64'd0);
    step();
    step();
    pdata_ready_i = 1'b1;
    release_and_clear(busy, stale);
    check("reclear_cycles", busy, 64'd256);
    check("reclear_stale", stale, 64'd0);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (pdata_valid_o) stale++;
      step();
    end
    check("no_stale_after", stale, 64'd0);
    lookup(8'h05, 64'h0123_4567_89AB_CDEF, got, ptr, v, data, lat);
    check("post_rst_valid", {63'd0, got}, 64'd1);
    check("post_rst_val", {63'd0, v}, 64'd0);
    check("post_rst_task", data, 64'h0123_4567_89AB_CDEF);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
